pe_mac_vec: RTL
===============

Name: pe_mac_vec

Overview:
- Parametrised streaming multiply-accumulate processing element for the heavy-hash matrix stage.
- Each accepted beat carries WCOUNT unsigned nibble pairs (matrix M, SHA3 vector X). The products are summed through a registered adder tree and accumulated over BEATS beats.
- After BEATS beats the dot product is emitted on a valid/ready output, and accumulation restarts with no idle cycle.
- Successor of the fixed 4-nibble PE: generic width and depth, a backpressure handshake, beat counting, and an optional heavy-hash output shift.

Parameters:
- WCOUNT, 4, nibble pairs per beat (1..16)
- NW, 4, bits per element
- BEATS, 16, beats per dot product (≥1)
- ACC_W, 14, accumulator/output width; must be ≥ clog2(BEATS*WCOUNT*(2^NW-1)^2 + 1), otherwise elaboration error

Ports:
- clk, in, 1, clock, rising edge
- rst_n, in, 1, asynchronous active-low reset
- clr, in, 1, synchronous flush
- in_valid, in, 1, beat valid
- in_ready, out, 1, beat accepted when in_valid && in_ready
- M, in, WCOUNT*NW, matrix nibbles; element i is M[i*NW +: NW]
- X, in, WCOUNT*NW, vector nibbles, same packing as M
- out_valid, out, 1, result valid
- out_ready, in, 1, downstream ready
- out_data, out, ACC_W, dot-product result
- beat_idx, out, clog2(BEATS) (min 1), index of the next beat to be accumulated
- busy, out, 1, any pipeline stage, the accumulator or the output register holds data

Behaviour:
- Reset (rst_n low, asynchronous) clears:
  - out_valid=0, out_data=0, beat_idx=0, busy=0
  - all stage valid bits and the accumulator
  - in_ready=1 after reset.
- Global advance: adv = !(out_valid && !out_ready). in_ready = adv. When adv=0 every stage holds its state, including the accumulator and beat_idx.
- Pipeline:
  - S1 registers the WCOUNT products, each 2*NW bits.
  - S2 registers the adder-tree sum, width clog2(WCOUNT*(2^NW-1)^2+1).
  - S3 accumulates: acc <= acc + S2 sum, zero-extended to ACC_W, modulo 2^ACC_W.
  - Stage valid bits propagate with the data; an invalid stage contributes 0 and does not advance beat_idx.
- Beat counting: beat_idx increments on each valid S3 update and wraps from BEATS-1 to 0.
- Completion: on the valid S3 update with beat_idx==BEATS-1:
  - out_data <= acc + sum (or the shifted value, see Optional Feature)
  - out_valid <= 1
  - acc <= 0 in the same cycle, so the first beat of the next product accumulates from 0.
- Latency: final beat accepted in cycle t gives out_valid=1 in cycle t+3, with no backpressure.
- Output handshake:
  - out_valid stays high and out_data stays stable until out_valid && out_ready.
  - Completion in the same cycle as a consumed result is legal (adv=1) and reloads out_valid=1.
- Throughput: one beat per cycle sustained while out_ready=1. BEATS=1 gives one result per cycle.
- clr, synchronous, priority over all input:
  - clears stage valids, acc, beat_idx and out_valid
  - the beat presented in the clr cycle is dropped (in_ready is still driven as adv)
  - a pending out_valid is discarded.
- rst_n asserted mid-operation: immediate clear of all state. No partial result is ever emitted.
- M/X are ignored when in_valid=0.

Optional Feature:
- Macro PE_MAC_SHIFT_EN.
- Defined: the completion value is (acc+sum) >> (ACC_W-NW), zero-extended into out_data, giving the heavy-hash nibble in out_data[NW-1:0].
- Undefined: the full ACC_W-bit sum is output.
- Latency and handshake are identical in both builds.

Decomposition:
- Package pe_mac_pkg holds:
  - localparam function for the required accumulator width
  - typedef for the nibble element and product types
  - the tree-sum width function
- One sub-module, pe_mac_tree: parametrised WCOUNT-input registered adder tree for S1→S2, with a valid-in/valid-out and hold enable.
- The top module keeps the counter, accumulator and output handshake.

Test Plan:
- All nibbles 15, WCOUNT=4, BEATS=16, out_ready=1, 16 back-to-back beats → out_data=14400 (0x3840) exactly 3 cycles after the last beat; with PE_MAC_SHIFT_EN → out_data=14.
- Two back-to-back products: first with M=X=1, second with M=2, X=3 → results 64 then 384 on consecutive result slots with no idle cycle; beat_idx wraps 15→0.
- Backpressure: out_ready=0 when result 64 arrives → in_ready=0, out_data held, beat_idx frozen; release after 5 cycles → handshake completes and the next product is still correct (384).
- clr asserted after beat 7 of a product → out_valid stays 0; the next 16 beats with M=X=1 → 64 (no residue).
- rst_n pulsed low mid-product and asynchronously (between clock edges) → outputs 0 immediately; after release a fresh product gives the correct value.
- Bubbles: in_valid toggling 1/0 with random M/X on idle cycles → result equals the reference-model dot product of the accepted beats only.

Source files
------------

// File: rtl/pe_mac_pkg.sv
// pe_mac_pkg: shared types and width helpers for the pe_mac_vec processing element.
//   nibble_t / prod_t  canonical 4-bit element and its 8-bit product
//   pe_tree_w()        width of one beat's adder-tree sum
//   pe_acc_req_w()     minimum accumulator width for a full dot product
//   pe_idx_w()         width of the beat index (at least 1 bit)
package pe_mac_pkg;

  localparam int PE_NW_DEF = 4;

  typedef logic [PE_NW_DEF-1:0]   nibble_t;
  typedef logic [2*PE_NW_DEF-1:0] prod_t;

  // Bits needed to hold wcount products of two maximal nw-bit elements.
  function automatic int pe_tree_w(input int wcount, input int nw);
    longint emax;
    emax = (longint'(1) << nw) - 1;
    return $clog2(longint'(wcount) * emax * emax + 1);
  endfunction

  // Bits needed to hold beats worth of maximal tree sums without wrapping.
  function automatic int pe_acc_req_w(input int beats, input int wcount, input int nw);
    longint emax;
    emax = (longint'(1) << nw) - 1;
    return $clog2(longint'(beats) * longint'(wcount) * emax * emax + 1);
  endfunction

  function automatic int pe_idx_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/pe_mac_tree.sv
// pe_mac_tree: registered WCOUNT-input adder tree (pipeline stage S1 -> S2).
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   clr           synchronous flush of the stage valid bit
//   en            hold enable; when low the stage keeps its contents
//   in_valid      S1 stage valid
//   in_prod       WCOUNT packed products, product i at [i*2*NW +: 2*NW]
//   out_valid     S2 stage valid
//   out_sum       registered sum of the products
module pe_mac_tree
  import pe_mac_pkg::*;
#(
  parameter int WCOUNT = 4,
  parameter int NW     = 4,
  parameter int SUM_W  = pe_tree_w(WCOUNT, NW)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic                     in_valid,
  input  logic [WCOUNT*2*NW-1:0]   in_prod,
  output logic                     out_valid,
  output logic [SUM_W-1:0]         out_sum
);

  localparam int PW = 2 * NW;

  logic [SUM_W-1:0] tree_sum;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic             valid_q, valid_d;

  // Written as a flat reduction; synthesis balances it into a tree.
  always_comb begin
    tree_sum = '0;
    for (int i = 0; i < WCOUNT; i++) begin
      tree_sum = tree_sum + SUM_W'(in_prod[i*PW +: PW]);
    end
  end

  // The sum register only loads on valid beats, so idle cycles do not toggle it.
  always_comb begin
    valid_d = valid_q;
    sum_d   = sum_q;
    if (clr) begin
      valid_d = 1'b0;
    end else if (en) begin
      valid_d = in_valid;
      if (in_valid) begin
        sum_d = tree_sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
    end else begin
      valid_q <= valid_d;
      sum_q   <= sum_d;
    end
  end

  assign out_valid = valid_q;
  assign out_sum   = sum_q;

endmodule

// File: rtl/pe_mac_vec.sv
// pe_mac_vec: streaming multiply-accumulate processing element.
// Each accepted beat carries WCOUNT unsigned NW-bit pairs (M, X). Products are
// registered (S1), summed by pe_mac_tree (S2) and accumulated (S3) over BEATS
// beats; the dot product then appears on a valid/ready output.
// Optional build macro: PE_MAC_SHIFT_EN -- output (acc+sum) >> (ACC_W-NW)
// instead of the full accumulator value.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   clr               synchronous flush of pipeline, accumulator, index, result
//   in_valid/in_ready input beat handshake
//   M, X              packed elements, element i at [i*NW +: NW]
//   out_valid/out_ready/out_data  result handshake and value
//   beat_idx          index of the next beat to be accumulated
//   busy              any stage, the accumulator or the result holds data
//
// Handshake: a transfer happens on a rising edge where valid && ready. The
// producer keeps valid and data stable until that edge. in_ready does not
// depend on in_valid; it is low only while a result is held (out_valid &&
// !out_ready), and then every stage freezes.
module pe_mac_vec
  import pe_mac_pkg::*;
#(
  parameter int WCOUNT = 4,
  parameter int NW     = 4,
  parameter int BEATS  = 16,
  parameter int ACC_W  = 14,
  localparam int BI_W  = pe_idx_w(BEATS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WCOUNT*NW-1:0]   M,
  input  logic [WCOUNT*NW-1:0]   X,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_W-1:0]       out_data,
  output logic [BI_W-1:0]        beat_idx,
  output logic                   busy
);

  localparam int PW    = 2 * NW;
  localparam int SUM_W = pe_tree_w(WCOUNT, NW);
  localparam int REQ_W = pe_acc_req_w(BEATS, WCOUNT, NW);

  if (WCOUNT < 1 || WCOUNT > 16) begin : g_wcount_check
    $error("pe_mac_vec: WCOUNT must be in 1..16");
  end
  if (BEATS < 1) begin : g_beats_check
    $error("pe_mac_vec: BEATS must be at least 1");
  end
  if (ACC_W < REQ_W) begin : g_acc_w_check
    $error("pe_mac_vec: ACC_W too narrow for BEATS*WCOUNT full-scale products");
  end

  // Global advance: everything moves unless a result is stuck at the output.
  logic adv;

  // S1: products
  logic [WCOUNT*PW-1:0] prod_q, prod_d;
  logic                 s1_valid_q, s1_valid_d;

  // S2: tree sum (inside pe_mac_tree)
  logic                 s2_valid;
  logic [SUM_W-1:0]     s2_sum;

  // S3: accumulator, beat index, result register
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [BI_W-1:0]      beat_q, beat_d;
  logic                 out_valid_q, out_valid_d;
  logic [ACC_W-1:0]     out_data_q, out_data_d;

  logic [ACC_W-1:0]     acc_sum;
  logic [ACC_W-1:0]     result;
  logic                 last_beat;

  assign adv      = !(out_valid_q && !out_ready);
  assign in_ready = adv;

  always_comb begin
    prod_d     = prod_q;
    s1_valid_d = s1_valid_q;
    if (clr) begin
      s1_valid_d = 1'b0;
    end else if (adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        for (int i = 0; i < WCOUNT; i++) begin
          prod_d[i*PW +: PW] = PW'(M[i*NW +: NW]) * PW'(X[i*NW +: NW]);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      prod_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      prod_q     <= prod_d;
    end
  end

  pe_mac_tree #(
    .WCOUNT (WCOUNT),
    .NW     (NW),
    .SUM_W  (SUM_W)
  ) u_tree (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .en        (adv),
    .in_valid  (s1_valid_q),
    .in_prod   (prod_q),
    .out_valid (s2_valid),
    .out_sum   (s2_sum)
  );

  assign acc_sum   = acc_q + ACC_W'(s2_sum);
  assign last_beat = (beat_q == BI_W'(BEATS - 1));

`ifdef PE_MAC_SHIFT_EN
  // Keep only the top NW bits: the heavy-hash nibble lands in out_data[NW-1:0].
  assign result = acc_sum >> (ACC_W - NW);
`else
  assign result = acc_sum;
`endif

  always_comb begin
    acc_d       = acc_q;
    beat_d      = beat_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (clr) begin
      acc_d       = '0;
      beat_d      = '0;
      out_valid_d = 1'b0;
    end else if (adv) begin
      // adv implies any held result is consumed on this edge.
      out_valid_d = 1'b0;
      if (s2_valid) begin
        if (last_beat) begin
          // Restart from zero so the next product has no residue.
          out_data_d  = result;
          out_valid_d = 1'b1;
          acc_d       = '0;
          beat_d      = '0;
        end else begin
          acc_d  = acc_sum;
          beat_d = beat_q + BI_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      beat_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      acc_q       <= acc_d;
      beat_q      <= beat_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign beat_idx  = beat_q;
  // A nonzero beat index means the accumulator holds a partial product.
  assign busy      = s1_valid_q | s2_valid | (beat_q != '0) | out_valid_q;

endmodule
